// File: rtl/bslu_pkg.sv
// ============================================================================
// Module  : bslu_pkg
// Brief   : Shared types for the bit-serial logic unit (opcode and FSM state
//           encodings, field widths).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bslu_pkg;

  // Opcode field width on the operand interface
  localparam int OP_W    = 2;
  // FSM state register width
  localparam int STATE_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage : bslu_pkg

`default_nettype wire

// File: rtl/bslu_bit_cell.sv
// ============================================================================
// Module  : bslu_bit_cell
// Brief   : Single reusable 1-bit logic gate (OR/AND/XOR/NOR), purely
//           combinational.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bslu_bit_cell
  import bslu_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  op_e  op_i,
  output logic y_o
);

  // Select the gate function for the current bit
  always_comb begin
    y_o = 1'b0;
    case (op_i)
      OP_OR:   y_o = a_i | b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      default: y_o = 1'b0;
    endcase
  end

endmodule : bslu_bit_cell

`default_nettype wire

// File: rtl/bit_serial_logic_unit.sv
// ============================================================================
// Module  : bit_serial_logic_unit
// Brief   : Bit-serial bitwise logic stage. Accepts two WIDTH-bit operands and
//           an opcode over valid/ready, evaluates one bit per clock LSB first
//           through a single gate cell, and returns the word over valid/ready.
//           Optional zero flag: define BSLU_ZERO_FLAG_EN to add out_zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serial_logic_unit
  import bslu_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef BSLU_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int                   COUNT_W    = $clog2(WIDTH + 1);
  localparam logic [COUNT_W-1:0]   LAST_COUNT = COUNT_W'(WIDTH - 1);

  state_e             state_q;
  state_e             state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_d;
  op_e                op_q;
  logic [COUNT_W-1:0] count_q;

  logic               accept;
  logic               handoff;
  logic               last_bit;
  logic               cell_y;

  // Handshake qualifiers; operands are only looked at in IDLE
  assign accept   = (state_q == S_IDLE)  && in_valid;
  assign handoff  = (state_q == S_DONE)  && out_ready;
  assign last_bit = (state_q == S_SHIFT) && (count_q == LAST_COUNT);

  // The one shared gate, always fed from the LSB of the shifting operands
  bslu_bit_cell u_bit_cell (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .op_i (op_q),
    .y_o  (cell_y)
  );

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB
  assign res_d = {cell_y, res_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)                state_d = S_SHIFT;
      S_SHIFT: if (count_q == LAST_COUNT)   state_d = S_DONE;
      S_DONE:  if (out_ready)               state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  // Handshake/status outputs decoded from state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_SHIFT: busy      = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  // Operand latch, serial shift, result accumulation and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= OP_OR;
      count_q <= '0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_b;
      op_q    <= op_e'(in_op);
      count_q <= '0;
    end else if (state_q == S_SHIFT) begin
      a_q     <= {1'b0, a_q[WIDTH-1:1]};
      b_q     <= {1'b0, b_q[WIDTH-1:1]};
      res_q   <= res_d;
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign out_data = res_q;

`ifdef BSLU_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag captured with the final bit, dropped when the word is handed off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (last_bit) begin
      zero_q <= (res_d == '0);
    end else if (handoff) begin
      zero_q <= 1'b0;
    end
  end

  assign out_zero = zero_q;
`else
  logic unused_flags;
  assign unused_flags = last_bit ^ handoff;
`endif

endmodule : bit_serial_logic_unit

`default_nettype wire

// File: tb/tb_bit_serial_logic_unit.sv
// ============================================================================
// Module  : tb_bit_serial_logic_unit
// Brief   : Self-checking bench for bit_serial_logic_unit (WIDTH=8): directed
//           literal cases plus randomized traffic against a transaction model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_logic_unit;

  localparam int WIDTH = 8;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             in_valid  = 1'b0;
  logic [WIDTH-1:0] in_a      = '0;
  logic [WIDTH-1:0] in_b      = '0;
  logic [1:0]       in_op     = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             busy;
`ifdef BSLU_ZERO_FLAG_EN
  logic             out_zero;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_sent   = 0;
  bit rnd_mode = 1'b0;

  always #5 clk = ~clk;

  bit_serial_logic_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef BSLU_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [1:0] op);
    case (op)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // ---------------- transaction-level model ----------------
  // A word accepted on edge number t is presented from edge t+WIDTH until the
  // edge on which out_ready is seen high; the unit is unavailable meanwhile.
  bit               m_active = 1'b0;
  int               cyc      = 0;
  int               m_t_acc  = 0;
  logic [WIDTH-1:0] m_exp    = '0;
  int               n_acc    = 0;
  int               n_done   = 0;

  function automatic bit m_valid();
    return m_active && ((cyc - m_t_acc) >= WIDTH);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit v;
    if (rst) begin
      m_active <= 1'b0;
    end else begin
      v = m_valid();
      cyc <= cyc + 1;
      if (!m_active) begin
        if (in_valid) begin
          m_active <= 1'b1;
          m_t_acc  <= cyc + 1;
          m_exp    <= ref_op(in_a, in_b, in_op);
          n_acc    <= n_acc + 1;
        end
      end else if (v && out_ready) begin
        m_active <= 1'b0;
        n_done   <= n_done + 1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    bit ev;
    if (rst) begin
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_in_ready",  64'(in_ready),  64'(1));
      check("rst_busy",      64'(busy),      64'(0));
      check("rst_out_data",  64'(out_data),  64'(0));
`ifdef BSLU_ZERO_FLAG_EN
      check("rst_out_zero",  64'(out_zero),  64'(0));
`endif
    end else begin
      ev = m_valid();
      check("in_ready",  64'(in_ready),  64'(!m_active));
      check("out_valid", 64'(out_valid), 64'(ev));
      check("busy",      64'(busy),      64'(m_active));
      if (ev) check("out_data", 64'(out_data), 64'(m_exp));
`ifdef BSLU_ZERO_FLAG_EN
      check("out_zero", 64'(out_zero), 64'(ev && (m_exp == '0)));
`endif
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] op);
    bit ok;
    bit acc;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      acc = in_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    // Scribble the operand bus to show operands are latched
    in_a  = WIDTH'($urandom);
    in_b  = WIDTH'($urandom);
    in_op = 2'($urandom);
    n_sent++;
    if (!ok) check("accept_timeout", 64'(0), 64'(1));
  endtask

  // Accept, then count cycles with in_ready low and capture the result word
  task automatic run_b2b(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] op, input logic [WIDTH-1:0] lit, output logic zero_seen);
    int n;
    logic [WIDTH-1:0] got;
    got       = 'x;
    zero_seen = 1'b0;
    send(a, b, op);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        got = out_data;
`ifdef BSLU_ZERO_FLAG_EN
        zero_seen = out_zero;
`endif
      end
      tick();
      if (in_ready) break;
      n++;
    end
    check({name, "_data"}, 64'(got), 64'(lit));
    check({name, "_ready_low"}, 64'(n), 64'(WIDTH + 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    int seen;
    logic z;

    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("reset_out_data",  64'(out_data),  64'(0));
    check("reset_in_ready",  64'(in_ready),  64'(1));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_busy",      64'(busy),      64'(0));
    tick();

    // OR with latency measurement and backpressure
    out_ready = 1'b0;
    send(8'hA5, 8'h0F, 2'b00);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("or_latency", 64'(n), 64'(WIDTH));
    check("or_data",    64'(out_data), 64'(8'hAF));
    repeat (5) begin
      tick();
      check("bp_data",      64'(out_data),  64'(8'hAF));
      check("bp_in_ready",  64'(in_ready),  64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", 64'(in_ready),  64'(1));
    check("bp_release_valid", 64'(out_valid), 64'(0));

    // Back-to-back with out_ready held high
    run_b2b("and", 8'hF0, 8'h3C, 2'b01, 8'h30, z);
    run_b2b("xor", 8'hFF, 8'h0F, 2'b10, 8'hF0, z);
    run_b2b("nor0", 8'h00, 8'h00, 2'b11, 8'hFF, z);
    run_b2b("nor1", 8'hFF, 8'h00, 2'b11, 8'h00, z);

    // Zero flag literals
    run_b2b("zand", 8'h0F, 8'hF0, 2'b01, 8'h00, z);
`ifdef BSLU_ZERO_FLAG_EN
    check("zero_flag_set", 64'(z), 64'(1));
`endif
    run_b2b("zor", 8'h01, 8'h00, 2'b00, 8'h01, z);
`ifdef BSLU_ZERO_FLAG_EN
    check("zero_flag_clr", 64'(z), 64'(0));
`endif

    // Reset in the middle of a shift
    send(8'h5A, 8'hC3, 2'b10);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("abort_out_data",  64'(out_data),  64'(0));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_in_ready",  64'(in_ready),  64'(1));
    check("abort_busy",      64'(busy),      64'(0));
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'(0));

    // Randomized traffic with random backpressure
    n_sent = 0;
    n_acc  = 0;
    n_done = 0;
    rnd_mode = 1'b1;
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom));
    end
    n = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    rnd_mode  = 1'b0;
    out_ready = 1'b1;
    check("drain_timeout",  64'(n < 300), 64'(1));
    tick();
    check("rnd_accepted",  64'(n_acc),  64'(n_sent));
    check("rnd_completed", 64'(n_done), 64'(n_sent));

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_bit_serial_logic_unit

`default_nettype wire
